// File: rtl/vga_sincronismo.sv
// ---------------------------------------------------------------------------
// vga_sincronismo
// Raster timing generator for 640x480@60 Hz VGA, clocked by the pixel clock.
// Generates the raw scan coordinates, the DAC sync/blank strobes (delayed by
// PIPE_DELAY cycles to match the renderer's registered RGB path) and the
// line/frame ticks used by the game logic.
//
// Ports
//   VGA_CLK          in   pixel clock, rising edge
//   reset            in   asynchronous, active-high
//   VGA_X, VGA_Y     out  raw horizontal/vertical counters (no offset)
//   VGA_HS, VGA_VS   out  active-low syncs, delayed PIPE_DELAY cycles
//   VGA_BLANK_N      out  high in the visible window, delayed PIPE_DELAY
//   VGA_SYNC_N       out  tied low
//   pixel_ativo      out  visible-window flag aligned with VGA_X/VGA_Y
//   line_tick        out  high while VGA_X == 0
//   frame_tick       out  high at (0, first line of vertical front porch)
//   contador_quadros out  completed-frame counter, wraps
// ---------------------------------------------------------------------------
module vga_sincronismo #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int PIPE_DELAY = 2
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        pixel_ativo,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] contador_quadros
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  // First blanking line after the picture: game state updates here.
  localparam logic [9:0] V_TICK_LINE = 10'(V_SYNC + V_BACK + V_ACTIVE);

  // Counter and decode state
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] quadros_q, quadros_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;
  logic        pix_q, pix_d;
  logic        line_tick_q, line_tick_d;
  logic        frame_tick_q, frame_tick_d;

  always_comb begin
    x_d       = x_q + 10'd1;
    y_d       = y_q;
    quadros_d = quadros_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d       = '0;
        quadros_d = quadros_q + 16'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end

    // Decode from next-state so every flag lands in the same register stage
    // as the coordinates it describes.
    hs_raw_d     = !(x_d < H_SYNC_END);
    vs_raw_d     = !(y_d < V_SYNC_END);
    pix_d        = (x_d >= H_VIS_FIRST) && (x_d <= H_VIS_LAST) &&
                   (y_d >= V_VIS_FIRST) && (y_d <= V_VIS_LAST);
    line_tick_d  = (x_d == 10'd0);
    frame_tick_d = (x_d == 10'd0) && (y_d == V_TICK_LINE);
  end

  // Reset values are the decode of (0,0): line_tick set, syncs asserted.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      quadros_q    <= '0;
      hs_raw_q     <= 1'b0;
      vs_raw_q     <= 1'b0;
      pix_q        <= 1'b0;
      line_tick_q  <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      quadros_q    <= quadros_d;
      hs_raw_q     <= hs_raw_d;
      vs_raw_q     <= vs_raw_d;
      pix_q        <= pix_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Delay line for {hs, vs, blank_n}. Stage 0 takes the decode; the last
  // stage drives the pins. Stages reset to "sync inactive, blanked".
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign VGA_HS      = hs_raw_q;
      assign VGA_VS      = vs_raw_q;
      assign VGA_BLANK_N = pix_q;
    end else begin : g_delay
      logic [3*PIPE_DELAY-1:0] chain_q, chain_d;

      for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign chain_d[2:0] = {hs_raw_q, vs_raw_q, pix_q};
        end else begin : g_body
          assign chain_d[3*gi +: 3] = chain_q[3*(gi-1) +: 3];
        end
      end

      always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
          chain_q <= {PIPE_DELAY{3'b110}};
        end else begin
          chain_q <= chain_d;
        end
      end

      assign VGA_HS      = chain_q[3*(PIPE_DELAY-1) + 2];
      assign VGA_VS      = chain_q[3*(PIPE_DELAY-1) + 1];
      assign VGA_BLANK_N = chain_q[3*(PIPE_DELAY-1)];
    end
  endgenerate

  assign VGA_X            = x_q;
  assign VGA_Y            = y_q;
  assign VGA_SYNC_N       = 1'b0;
  assign pixel_ativo      = pix_q;
  assign line_tick        = line_tick_q;
  assign frame_tick       = frame_tick_q;
  assign contador_quadros = quadros_q;

endmodule

// File: tb/tb_vga_sincronismo.sv
// ---------------------------------------------------------------------------
// Bench for vga_sincronismo. Instance A uses the real 640x480 timing with
// PIPE_DELAY=2 (a few dozen lines only). Instance B uses a tiny raster
// (16x10) with PIPE_DELAY=0 so whole frames, frame ticks and the frame
// counter wrap fit in a short run. Both share clock and reset.
// ---------------------------------------------------------------------------
module tb_vga_sincronismo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A outputs
  logic [9:0]  a_x, a_y;
  logic        a_hs, a_vs, a_bn, a_sn, a_pix, a_lt, a_ft;
  logic [15:0] a_q;
  // Instance B outputs
  logic [9:0]  b_x, b_y;
  logic        b_hs, b_vs, b_bn, b_sn, b_pix, b_lt, b_ft;
  logic [15:0] b_q;

  vga_sincronismo dut_a (
    .VGA_CLK(clk), .reset(rst),
    .VGA_X(a_x), .VGA_Y(a_y), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .pixel_ativo(a_pix),
    .line_tick(a_lt), .frame_tick(a_ft), .contador_quadros(a_q)
  );

  vga_sincronismo #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(2),
    .PIPE_DELAY(0)
  ) dut_b (
    .VGA_CLK(clk), .reset(rst),
    .VGA_X(b_x), .VGA_Y(b_y), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .pixel_ativo(b_pix),
    .line_tick(b_lt), .frame_tick(b_ft), .contador_quadros(b_q)
  );

  int checks = 0;
  int errors = 0;

  // Expected state, advanced once per clock by step()
  int          ax, ay, bx, by;
  logic [15:0] aq, bq;
  logic [2:0]  ahist0, ahist1;           // {hs,vs,blank_n} 1 and 2 cycles old
  // Per-cycle mismatch tallies and statistics
  int a_cnt_err, a_dly_err, a_tick_err, a_pix_err;
  int b_cnt_err, b_sig_err, b_tick_err;
  int hs_low, vs_low, bn_high, pix_outside;
  int b_ft_seen, b_ft_exp, b_ft_gap_err, b_last_ft, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] a_decode(input int x, input int y);
    logic hs, vs, pix;
    hs  = !(x < 96);
    vs  = !(y < 2);
    pix = (x >= 144) && (x <= 783) && (y >= 35) && (y <= 514);
    return {hs, vs, pix};
  endfunction

  function automatic logic [2:0] b_decode(input int x, input int y);
    logic hs, vs, pix;
    hs  = !(x < 4);
    vs  = !(y < 2);
    pix = (x >= 6) && (x <= 13) && (y >= 4) && (y <= 7);
    return {hs, vs, pix};
  endfunction

  task automatic model_reset();
    ax = 0; ay = 0; aq = '0;
    bx = 0; by = 0; bq = '0;
    ahist0 = 3'b110; ahist1 = 3'b110;
  endtask

  // Advance one clock, update the model, then sample at the falling edge.
  task automatic step();
    logic [2:0] bd;
    ahist1 = ahist0;
    ahist0 = a_decode(ax, ay);
    ax++;
    if (ax == 800) begin
      ax = 0; ay++;
      if (ay == 525) begin ay = 0; aq++; end
    end
    bx++;
    if (bx == 16) begin
      bx = 0; by++;
      if (by == 10) begin by = 0; bq++; end
    end
    cyc++;
    @(negedge clk);

    if (a_x !== 10'(ax) || a_y !== 10'(ay) || a_q !== aq) a_cnt_err++;
    if ({a_hs, a_vs, a_bn} !== ahist1) a_dly_err++;
    if (a_lt !== (ax == 0) || a_ft !== (ax == 0 && ay == 515) || a_sn !== 1'b0) a_tick_err++;
    if (a_pix !== a_decode(ax, ay)[0]) a_pix_err++;
    if (a_pix === 1'b1 && (ay < 35 || ay > 514)) pix_outside++;
    if (a_hs === 1'b0) hs_low++;
    if (a_vs === 1'b0) vs_low++;
    if (a_bn === 1'b1) bn_high++;

    bd = b_decode(bx, by);
    if (b_x !== 10'(bx) || b_y !== 10'(by) || b_q !== bq) b_cnt_err++;
    if ({b_hs, b_vs, b_bn, b_pix} !== {bd, bd[0]}) b_sig_err++;
    if (b_lt !== (bx == 0) || b_sn !== 1'b0) b_tick_err++;
    if (bx == 0 && by == 8) b_ft_exp++;
    if (b_ft === 1'b1) begin
      b_ft_seen++;
      if (b_last_ft >= 0 && cyc - b_last_ft != 160) b_ft_gap_err++;
      b_last_ft = cyc;
    end
  endtask

  initial begin
    int guard;
    a_cnt_err = 0; a_dly_err = 0; a_tick_err = 0; a_pix_err = 0;
    b_cnt_err = 0; b_sig_err = 0; b_tick_err = 0;
    hs_low = 0; vs_low = 0; bn_high = 0; pix_outside = 0;
    b_ft_seen = 0; b_ft_exp = 0; b_ft_gap_err = 0; b_last_ft = -1; cyc = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(a_x), 32'd0);
    check("rst_y", 32'(a_y), 32'd0);
    check("rst_hs_vs_bn", 32'({a_hs, a_vs, a_bn}), 32'b110);
    check("rst_ticks_pix", 32'({a_lt, a_ft, a_pix}), 32'b100);
    check("rst_quadros", 32'(a_q), 32'd0);
    check("rst_sync_n", 32'(a_sn), 32'd0);
    check("rst_b_line_tick", 32'(b_lt), 32'd1);

    // Release; first edge gives X=1, delayed outputs still at reset value
    rst = 1'b0;
    model_reset();
    step();
    check("first_x", 32'(a_x), 32'd1);
    check("first_line_tick", 32'(a_lt), 32'd0);
    check("first_hs_held", 32'(a_hs), 32'd1);
    step();
    check("hs_fall_at_x2", 32'({a_x, a_hs}), 32'({10'd2, 1'b0}));
    repeat (798) step();
    check("line_wrap_xy", 32'({a_x, a_y}), 32'({10'd0, 10'd1}));
    check("line_tick_t800", 32'(a_lt), 32'd1);

    // One full line: HS low for 96 cycles
    hs_low = 0;
    repeat (800) step();
    check("hs_low_per_line", 32'(hs_low), 32'd96);

    // Advance to first visible line, count BLANK_N over one line
    guard = 0;
    while (!(ax == 0 && ay == 35) && guard < 40000) begin step(); guard++; end
    check("reach_line35", 32'(guard < 40000), 32'd1);
    bn_high = 0;
    repeat (800) step();
    check("blank_n_per_line", 32'(bn_high), 32'd640);
    check("vs_low_total", 32'(vs_low), 32'd1600);

    // Per-cycle model agreement over the run so far
    check("a_counter_err", 32'(a_cnt_err), 32'd0);
    check("a_delay_err", 32'(a_dly_err), 32'd0);
    check("a_tick_err", 32'(a_tick_err), 32'd0);
    check("a_pix_err", 32'(a_pix_err), 32'd0);
    check("a_pix_outside", 32'(pix_outside), 32'd0);
    check("b_counter_err", 32'(b_cnt_err), 32'd0);
    check("b_undelayed_err", 32'(b_sig_err), 32'd0);
    check("b_line_tick_err", 32'(b_tick_err), 32'd0);
    check("b_frame_ticks", 32'(b_ft_seen), 32'(b_ft_exp));
    check("b_frame_tick_gap", 32'(b_ft_gap_err), 32'd0);
    check("b_quadros", 32'(b_q), 32'(cyc / 160));

    // Mid-line asynchronous reset at X=400
    guard = 0;
    while (ax != 400 && guard < 1000) begin step(); guard++; end
    check("reach_x400", 32'(a_x), 32'd400);
    rst = 1'b1;
    #1;
    check("async_rst_xy", 32'({a_x, a_y}), 32'd0);
    check("async_rst_sync", 32'({a_hs, a_vs, a_bn}), 32'b110);
    check("async_rst_b_quadros", 32'(b_q), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_x", 32'(a_x), 32'd0);
    rst = 1'b0;
    model_reset();
    step();
    check("resume_x1", 32'(a_x), 32'd1);
    step();
    check("resume_x2_hs", 32'({a_x, a_hs}), 32'({10'd2, 1'b0}));

    // Frame counter wrap 0xFFFF -> 0 on instance B
    force dut_b.quadros_q = 16'hFFFF;
    #1;
    release dut_b.quadros_q;
    bq = 16'hFFFF;
    step();
    check("b_quadros_preload", 32'(b_q), 32'h0000FFFF);
    b_cnt_err = 0; b_sig_err = 0;
    repeat (170) step();
    check("b_quadros_wrap", 32'(b_q), 32'd0);
    check("b_counter_err2", 32'(b_cnt_err), 32'd0);
    check("b_hs_same_cycle", 32'(b_sig_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sincronismo.md
# vga_sincronismo

Raster timing generator for the 640x480@60 Hz VGA output, clocked by the 25.175 MHz pixel clock VGA_CLK. It produces the raw scan coordinates VGA_X/VGA_Y consumed by the screen renderer, the sync and blank strobes for the DAC, and frame/line ticks for the game logic. HS/VS/BLANK_N are delayed by a configurable pipeline depth so they stay aligned with the renderer's registered RGB output.

## Interface
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- PIPE_DELAY, 2, renderer latency in cycles; legal range 0..7

- VGA_CLK  in  1  pixel clock; all state on its rising edge
- reset  in  1  asynchronous, active-high
- VGA_X  out  10  raw horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
- VGA_Y  out  10  raw vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- VGA_HS  out  1  horizontal sync, active-low, delayed PIPE_DELAY
- VGA_VS  out  1  vertical sync, active-low, delayed PIPE_DELAY
- VGA_BLANK_N  out  1  high inside the visible window, delayed PIPE_DELAY
- VGA_SYNC_N  out  1  tied 0
- pixel_ativo  out  1  undelayed visible-window flag, aligned with VGA_X/VGA_Y
- line_tick  out  1  one-cycle pulse when VGA_X==0
- frame_tick  out  1  one-cycle pulse at the start of vertical front porch
- contador_quadros  out  16  completed-frame counter, wraps

## Operation
- Horizontal counter: increments every cycle; at H_TOTAL-1 it wraps to 0 and the vertical counter advances. The vertical counter wraps from V_TOTAL-1 to 0 on the same edge the horizontal counter wraps.
- VGA_X/VGA_Y are the counter registers; no offset. Visible origin is (H_SYNC+H_BACK, V_SYNC+V_BACK) = (144, 35); consumers subtract it.
- Undelayed decode, from the current counters:
  - hs_raw = 0 when VGA_X < H_SYNC
  - vs_raw = 0 when VGA_Y < V_SYNC
  - pixel_ativo = 1 when 144 <= VGA_X <= 783 and 35 <= VGA_Y <= 514
- Delay line: {hs_raw, vs_raw, pixel_ativo} pass through a PIPE_DELAY-deep shift register to VGA_HS/VGA_VS/VGA_BLANK_N. PIPE_DELAY=0 drives them directly from the decode.
- line_tick = 1 exactly in cycles where VGA_X==0.
- frame_tick = 1 exactly in the cycle where (VGA_X, VGA_Y) == (0, V_SYNC+V_BACK+V_ACTIVE) = (0, 515). This is the first blanking line after the last visible line, where game state updates.
- contador_quadros: increments by 1 on the edge where both counters wrap to (0,0). Wraps from 0xFFFF to 0.
- All tick and decode outputs are registered alongside the counters, computed from next-state values. Outputs never glitch combinationally.

## Timing
- Reset (asynchronous, any time including mid-frame):
  - VGA_X=0, VGA_Y=0, contador_quadros=0
  - line_tick=1, since it decodes (0,0); pixel_ativo=0; frame_tick=0
  - Every delay-line stage resets to HS=1, VS=1, BLANK_N=0 (sync inactive, blanked)
- First edge after reset release gives VGA_X=1.
- Line period: 800 cycles. Frame period: 800*525 = 420000 cycles.
- HS low for 96 consecutive cycles per line. VS low for 2 lines = 1600 cycles per frame.
- VGA_HS/VGA_VS/VGA_BLANK_N transition exactly PIPE_DELAY cycles after the counter value that causes the change.
  - Example: PIPE_DELAY=2 gives VGA_HS falling 2 cycles after VGA_X becomes 0, and rising 2 cycles after VGA_X becomes 96.
- Delayed outputs carry reset values for PIPE_DELAY cycles after reset release.
- frame_tick is 1 cycle wide, once per frame; line_tick fires 525 times per frame.
- Simultaneous wraps (799,524)->(0,0): the vertical wrap, the counter increment and line_tick all take effect on the same edge.

## Test plan
- Reset released at t0 -> VGA_X counts 0,1,2...; at 799 it returns to 0 and VGA_Y becomes 1; line_tick high at cycles t0 and t0+800.
- PIPE_DELAY=2, free-run one line -> VGA_HS low during the window where VGA_X runs 2..97 relative to counter sampling (96 cycles); VGA_BLANK_N high exactly 640 cycles per visible line.
- Run 2 frames -> frame_tick pulses exactly twice, 420000 cycles apart, each when (VGA_X,VGA_Y)=(0,515); contador_quadros reads 2.
- Count VS -> low for 1600 cycles starting at (0,0) + PIPE_DELAY; pixel_ativo is 0 for every cycle with VGA_Y<35 or VGA_Y>514.
- Assert reset at (400,300) for 3 cycles -> outputs immediately read VGA_X=0, VGA_Y=0, HS=VS=1, BLANK_N=0, contador_quadros=0; normal counting resumes on release.
- PIPE_DELAY=0 -> VGA_HS equals the undelayed decode (low iff VGA_X<96) in the same cycle; preload contador_quadros to 0xFFFF via force, cross a frame wrap -> reads 0.
